// File: rtl/ps2_key_manager.sv
// PS/2 scan-code set 2 frame decoder with a pressed-key bitmap for eight game keys,
// typematic repeat filtering and a small event FIFO drained by valid/ready.
module ps2_key_manager #(
  parameter int DEPTH     = 4,
  parameter bit REPEAT_EN = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     code_valid,
  input  logic [7:0]               code_byte,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [9:0]               evt_data,
  output logic [7:0]               key_state,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_E0    = 3'd1;
  localparam logic [2:0] S_F0    = 3'd2;
  localparam logic [2:0] S_E0F0  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;

  // Entry i is the scan code of key_state bit i.
  localparam logic [7:0][7:0] KEY_CODES = {8'h5A, 8'h29, 8'h42, 8'h3B,
                                           8'h23, 8'h1B, 8'h1C, 8'h1D};

  logic [2:0]    state, nxt_state;
  logic [2:0]    skip, nxt_skip;
  logic          done;
  logic [9:0]    ev;
  logic [7:0]    hit;
  logic          is_repeat, push, pop, wr_en, full, empty;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [9:0]    mem [DEPTH];

  always_comb begin
    nxt_state = state;
    nxt_skip  = skip;
    done      = 1'b0;
    ev        = 10'd0;
    if (code_valid) begin
      case (state)
        S_IDLE: begin
          case (code_byte)
            8'hE0: nxt_state = S_E0;
            8'hF0: nxt_state = S_F0;
            8'hE1: begin
              nxt_state = S_PAUSE;
              nxt_skip  = 3'd7;
            end
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
            end
            default: begin
              done = 1'b1;
              ev   = {2'b00, code_byte};
            end
          endcase
        end
        S_E0: begin
          if (code_byte == 8'hF0) begin
            nxt_state = S_E0F0;
          end else begin
            done      = 1'b1;
            ev        = {2'b10, code_byte};
            nxt_state = S_IDLE;
          end
        end
        S_F0: begin
          done      = 1'b1;
          ev        = {2'b01, code_byte};
          nxt_state = S_IDLE;
        end
        S_E0F0: begin
          done      = 1'b1;
          ev        = {2'b11, code_byte};
          nxt_state = S_IDLE;
        end
        S_PAUSE: begin
          // Pause frame body is opaque; only its length matters.
          nxt_skip = skip - 3'd1;
          if (skip == 3'd1) begin
            done      = 1'b1;
            ev        = {2'b10, 8'hE1};
            nxt_state = S_IDLE;
          end
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++)
      hit[i] = done && !ev[9] && (ev[7:0] == KEY_CODES[i]);
  end

  assign is_repeat = !ev[8] && |(hit & key_state);
  assign push      = done && !(is_repeat && !REPEAT_EN);
  assign full      = (fifo_count == FULL_CNT);
  assign empty     = (fifo_count == '0);
  assign pop       = !empty && evt_ready;
  assign wr_en     = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      skip       <= 3'd0;
      key_state  <= 8'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= nxt_state;
      skip  <= nxt_skip;
      if (ev[8]) key_state <= key_state & ~hit;
      else       key_state <= key_state | hit;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= ev;
  end

  assign evt_valid = !empty;
  assign evt_data  = empty ? 10'd0 : mem[rd_ptr];

endmodule

// File: tb/tb_ps2_key_manager.sv
// Bench for ps2_key_manager: directed frames plus random byte streams checked
// against a frame-level model; one instance per REPEAT_EN setting.
module tb_ps2_key_manager;
  logic       clk, rst, code_valid, evt_ready;
  logic [7:0] code_byte;
  logic       v0, v1, o0, o1;
  logic [9:0] d0, d1;
  logic [7:0] k0, k1;
  logic [2:0] c0, c1;

  int errors = 0;
  int checks = 0;

  ps2_key_manager #(.DEPTH(4), .REPEAT_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code_byte(code_byte),
    .evt_ready(evt_ready), .evt_valid(v0), .evt_data(d0), .key_state(k0),
    .fifo_count(c0), .overflow(o0));
  ps2_key_manager #(.DEPTH(4), .REPEAT_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code_byte(code_byte),
    .evt_ready(evt_ready), .evt_valid(v1), .evt_data(d1), .key_state(k1),
    .fifo_count(c1), .overflow(o1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model: bytes of the current frame, key bitmap, two event queues.
  logic [7:0] fr[$];
  logic [7:0] keys;
  logic [9:0] q0[$], q1[$];
  logic       mo0, mo1;
  logic [7:0] keymap [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h3B, 8'h42, 8'h29, 8'h5A};

  function automatic logic [9:0] head0();
    return (q0.size() > 0) ? q0[0] : 10'd0;
  endfunction
  function automatic logic [9:0] head1();
    return (q1.size() > 0) ? q1[0] : 10'd0;
  endfunction

  task automatic model_edge();
    logic done, rep, p0, p1;
    logic [9:0] ev;
    logic [7:0] b;
    done = 0; rep = 0; ev = 0; b = code_byte;
    if (rst) begin
      fr.delete(); keys = 0; q0.delete(); q1.delete(); mo0 = 0; mo1 = 0;
      return;
    end
    p0 = (q0.size() > 0) && evt_ready;
    p1 = (q1.size() > 0) && evt_ready;
    if (code_valid && !(fr.size() == 0 &&
        (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF))) begin
      fr.push_back(b);
      if (fr[0] == 8'hE1) begin
        if (fr.size() == 8) begin done = 1; ev = 10'h2E1; end
      end else if (!(fr.size() == 1 && (b == 8'hE0 || b == 8'hF0)) &&
                   !(fr.size() == 2 && fr[0] == 8'hE0 && b == 8'hF0)) begin
        done = 1;
        ev = {fr[0] == 8'hE0, fr.size() >= 2 && fr[fr.size()-2] == 8'hF0, b};
      end
      if (done) fr.delete();
    end
    if (done && !ev[9]) begin
      for (int i = 0; i < 8; i++) begin
        if (ev[7:0] == keymap[i]) begin
          if (ev[8]) keys[i] = 1'b0;
          else if (keys[i]) rep = 1;
          else keys[i] = 1'b1;
        end
      end
    end
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (done && !rep) begin
      if (q0.size() < 4) q0.push_back(ev); else mo0 = 1;
    end
    if (done) begin
      if (q1.size() < 4) q1.push_back(ev); else mo1 = 1;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic r, input logic rs);
    code_valid = v; code_byte = b; evt_ready = r; rst = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    code_valid = 0; rst = 0;
  endtask

  task automatic test_reset();
    step(0, 8'h00, 0, 1);
    checks++;
    if ({v0, d0, k0, c0, o0} !== 23'd0) begin
      errors++; $display("FAIL reset_u0 got v=%0b d=%h k=%h c=%0d o=%0b want all 0", v0, d0, k0, c0, o0);
    end
    checks++;
    if ({v1, d1, k1, c1, o1} !== 23'd0) begin
      errors++; $display("FAIL reset_u1 got v=%0b d=%h k=%h c=%0d o=%0b want all 0", v1, d1, k1, c1, o1);
    end
  endtask

  task automatic test_make_break();
    step(0, 0, 1, 1);
    step(1, 8'h1D, 1, 0);
    checks++;
    if (d0 !== 10'h01D || k0[0] !== 1'b1) begin
      errors++; $display("FAIL make_w got d=%h k=%h want d=01d k0=1", d0, k0);
    end
    step(1, 8'hF0, 1, 0);
    checks++;
    if (v0 !== 1'b0 || k0 !== 8'h01) begin
      errors++; $display("FAIL break_prefix got v=%0b k=%h want v=0 k=01", v0, k0);
    end
    step(1, 8'h1D, 1, 0);
    checks++;
    if (d0 !== 10'h11D || k0 !== 8'h00) begin
      errors++; $display("FAIL break_w got d=%h k=%h want d=11d k=00", d0, k0);
    end
  endtask

  task automatic test_ext_break();
    logic [7:0] seq [3] = '{8'hE0, 8'hF0, 8'h75};
    step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, seq[i], 1, 0);
    checks++;
    if (d0 !== 10'h375 || c0 !== 3'd1 || k0 !== 8'h00) begin
      errors++; $display("FAIL ext_break got d=%h c=%0d k=%h want d=375 c=1 k=00", d0, c0, k0);
    end
  endtask

  task automatic test_repeat();
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 8'h29, 0, 0);
    checks++;
    if (c0 !== 3'd1 || c1 !== 3'd3 || k0 !== 8'h40 || k1 !== 8'h40) begin
      errors++; $display("FAIL repeat_count got c0=%0d c1=%0d k0=%h k1=%h want 1 3 40 40", c0, c1, k0, k1);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (d1 !== 10'h029) begin
        errors++; $display("FAIL repeat_drain%0d got %h want 029", i, d1);
      end
      step(0, 0, 1, 0);
    end
    checks++;
    if (v1 !== 1'b0 || v0 !== 1'b0) begin
      errors++; $display("FAIL repeat_empty got v0=%0b v1=%0b want 0 0", v0, v1);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] mk [5]  = '{8'h1C, 8'h1B, 8'h23, 8'h3B, 8'h42};
    logic [9:0] exp [4] = '{10'h01B, 10'h023, 10'h03B, 10'h05A};
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, mk[i], 0, 0);
    checks++;
    if (c0 !== 3'd4 || o0 !== 1'b1 || d0 !== 10'h01C) begin
      errors++; $display("FAIL overflow got c=%0d o=%0b d=%h want 4 1 01c", c0, o0, d0);
    end
    step(1, 8'h5A, 1, 0);
    checks++;
    if (c0 !== 3'd4 || o0 !== 1'b1) begin
      errors++; $display("FAIL full_pushpop got c=%0d o=%0b want 4 1", c0, o0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (d0 !== exp[i]) begin
        errors++; $display("FAIL overflow_drain%0d got %h want %h", i, d0, exp[i]);
      end
      step(0, 0, 1, 0);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    step(0, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, seq[i], 1, 0);
      checks++;
      if (i < 7 && v0 !== 1'b0) begin
        errors++; $display("FAIL pause_early%0d got v=%0b want 0", i, v0);
      end else if (i == 7 && d0 !== 10'h2E1) begin
        errors++; $display("FAIL pause_event got %h want 2e1", d0);
      end
    end
    step(1, 8'h1D, 1, 0);
    checks++;
    if (d0 !== 10'h01D) begin
      errors++; $display("FAIL pause_idle got %h want 01d", d0);
    end
  endtask

  task automatic test_reset_midframe();
    step(0, 0, 1, 1);
    step(1, 8'hE0, 1, 0);
    step(1, 8'hF0, 1, 0);
    step(0, 8'h00, 1, 1);
    checks++;
    if ({v0, d0, k0, c0, o0} !== 23'd0) begin
      errors++; $display("FAIL midframe_rst got v=%0b d=%h c=%0d want 0", v0, d0, c0);
    end
    step(1, 8'h1D, 1, 0);
    checks++;
    if (d0 !== 10'h01D || k0 !== 8'h01) begin
      errors++; $display("FAIL midframe_after got d=%h k=%h want 01d 01", d0, k0);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    step(0, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 39);
      if (r < 16)      b = keymap[$urandom_range(0, 7)];
      else if (r < 22) b = 8'hF0;
      else if (r < 26) b = 8'hE0;
      else if (r == 26) b = 8'hE1;
      else if (r < 29) b = 8'hFA;
      else             b = 8'($urandom);
      step($urandom_range(0, 3) != 0, b, $urandom_range(0, 2) == 0, 0);
      checks++;
      if (v0 !== (q0.size() > 0) || d0 !== head0() || c0 !== 3'(q0.size()) ||
          k0 !== keys || o0 !== mo0) begin
        errors++;
        $display("FAIL rand_u0 n=%0d got v=%0b d=%h c=%0d k=%h o=%0b want d=%h c=%0d k=%h o=%0b",
                 n, v0, d0, c0, k0, o0, head0(), q0.size(), keys, mo0);
      end
      checks++;
      if (v1 !== (q1.size() > 0) || d1 !== head1() || c1 !== 3'(q1.size()) ||
          k1 !== keys || o1 !== mo1) begin
        errors++;
        $display("FAIL rand_u1 n=%0d got v=%0b d=%h c=%0d k=%h o=%0b want d=%h c=%0d k=%h o=%0b",
                 n, v1, d1, c1, k1, o1, head1(), q1.size(), keys, mo1);
      end
    end
  endtask

  initial begin
    rst = 1; code_valid = 0; code_byte = 0; evt_ready = 0; keys = 0; mo0 = 0; mo1 = 0;
    test_reset();
    test_make_break();
    test_ext_break();
    test_repeat();
    test_overflow();
    test_pause();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
